// File: rtl/quiz_round_ctrl.sv
// quiz_round_ctrl: round sequencer for the factorization game.
// Draws two operand digits (2..9) from the random-digit source, shows their
// product, collects a two-digit factor answer under a per-round countdown,
// scores it and repeats for ROUNDS rounds.
//
// Optional feature: define QUIZ_TIME_BONUS_EN to award 2 points instead of 1
// for a correct answer given with more than half the round time left.
module quiz_round_ctrl #(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned ROUND_SEC = 9,
  parameter int unsigned ROUNDS    = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic [3:0] rnd_num,
  output logic       rnd_run,
  input  logic [3:0] ans_digit,
  input  logic       ans_valid,
  output logic [6:0] product,
  output logic [3:0] time_left,
  output logic [3:0] score,
  output logic [3:0] round_no,
  output logic       busy,
  output logic       correct,
  output logic       wrong,
  output logic       timeout,
  output logic       done
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [3:0] SEC_LOAD   = 4'(ROUND_SEC);
  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);
`ifdef QUIZ_TIME_BONUS_EN
  localparam logic [3:0] HALF_SEC   = 4'(ROUND_SEC / 2);
`endif

  typedef enum logic [3:0] {
    StIdle,
    StDrawA,
    StWaitA,
    StDrawB,
    StWaitB,
    StShow,
    StAns1,
    StAns2,
    StJudge,
    StDone
  } state_e;

  state_e           state;
  logic [3:0]       op_a;
  logic [3:0]       op_b;
  logic [3:0]       f1;
  logic [DIV_W-1:0] div_cnt;

  logic             in_answer;
  logic             tick;
  logic             digit_ok;
  logic [7:0]       factor_prod;
  logic             answer_match;
  logic [4:0]       score_inc;
  logic [4:0]       score_sum;
  logic [3:0]       score_next;

  // Countdown tick, operand range check and answer scoring helpers.
  always_comb begin
    in_answer    = (state == StAns1) || (state == StAns2);
    tick         = in_answer && (div_cnt == DIV_LAST);
    digit_ok     = (rnd_num >= 4'd2) && (rnd_num <= 4'd9);
    // The second factor is consumed on the edge it is strobed, so it is
    // taken straight from ans_digit rather than from a register.
    factor_prod  = 8'(f1) * 8'(ans_digit);
    answer_match = (factor_prod == {1'b0, product});
`ifdef QUIZ_TIME_BONUS_EN
    score_inc    = (time_left > HALF_SEC) ? 5'd2 : 5'd1;
`else
    score_inc    = 5'd1;
`endif
    score_sum    = {1'b0, score} + score_inc;
    score_next   = (score_sum > 5'd15) ? 4'd15 : score_sum[3:0];
  end

  // Round sequencer with all outputs registered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= StIdle;
      op_a      <= 4'd0;
      op_b      <= 4'd0;
      f1        <= 4'd0;
      div_cnt   <= '0;
      product   <= 7'd0;
      time_left <= 4'd0;
      score     <= 4'd0;
      round_no  <= 4'd0;
      rnd_run   <= 1'b0;
      busy      <= 1'b0;
      correct   <= 1'b0;
      wrong     <= 1'b0;
      timeout   <= 1'b0;
      done      <= 1'b0;
    end else begin
      // Pulse outputs default low; each is raised for a single cycle below.
      rnd_run <= 1'b0;
      correct <= 1'b0;
      wrong   <= 1'b0;
      timeout <= 1'b0;

      case (state)
        StIdle, StDone: begin
          if (start) begin
            state    <= StDrawA;
            rnd_run  <= 1'b1;
            score    <= 4'd0;
            round_no <= 4'd1;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end

        StDrawA: state <= StWaitA;

        StWaitA: begin
          op_a    <= rnd_num;
          rnd_run <= 1'b1;
          state   <= digit_ok ? StDrawB : StDrawA;
        end

        StDrawB: state <= StWaitB;

        StWaitB: begin
          op_b <= rnd_num;
          if (digit_ok) begin
            state <= StShow;
          end else begin
            state   <= StDrawB;
            rnd_run <= 1'b1;
          end
        end

        StShow: begin
          product   <= 7'(op_a) * 7'(op_b);
          time_left <= SEC_LOAD;
          div_cnt   <= '0;
          state     <= StAns1;
        end

        StAns1: begin
          div_cnt <= tick ? '0 : div_cnt + 1'b1;
          if (tick && (time_left <= 4'd1)) begin
            time_left <= 4'd0;
            timeout   <= 1'b1;
            state     <= StJudge;
          end else begin
            if (tick) begin
              time_left <= time_left - 1'b1;
            end
            if (ans_valid) begin
              f1    <= ans_digit;
              state <= StAns2;
            end
          end
        end

        StAns2: begin
          div_cnt <= tick ? '0 : div_cnt + 1'b1;
          // A strobe on the final tick wins: judge it, leave time_left alone.
          if (ans_valid) begin
            state <= StJudge;
            if (answer_match) begin
              correct <= 1'b1;
              score   <= score_next;
            end else begin
              wrong <= 1'b1;
            end
          end else if (tick) begin
            if (time_left <= 4'd1) begin
              time_left <= 4'd0;
              timeout   <= 1'b1;
              state     <= StJudge;
            end else begin
              time_left <= time_left - 1'b1;
            end
          end
        end

        StJudge: begin
          if (round_no == LAST_ROUND) begin
            state <= StDone;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            round_no <= round_no + 1'b1;
            rnd_run  <= 1'b1;
            state    <= StDrawA;
          end
        end

        default: begin
          state <= StIdle;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Directed bench for quiz_round_ctrl (TICK_DIV=4, ROUND_SEC=3, ROUNDS=2),
// plus a 15-round instance for score saturation.
module tb_quiz_round_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       start, sat_start;
  logic [3:0] rnd_num, ans_digit;
  logic       ans_valid;

  logic       rnd_run, busy, correct, wrong, timeout, done;
  logic [6:0] product;
  logic [3:0] time_left, score, round_no;

  logic       s_rnd_run, s_busy, s_correct, s_wrong, s_timeout, s_done;
  logic [6:0] s_product;
  logic [3:0] s_time_left, s_score, s_round_no;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_score;
  int bonus;

  always #5 CLK = ~CLK;

  quiz_round_ctrl #(.TICK_DIV(4), .ROUND_SEC(3), .ROUNDS(2)) u_dut (
    .CLK(CLK), .RST(RST), .start(start), .rnd_num(rnd_num), .rnd_run(rnd_run),
    .ans_digit(ans_digit), .ans_valid(ans_valid), .product(product),
    .time_left(time_left), .score(score), .round_no(round_no), .busy(busy),
    .correct(correct), .wrong(wrong), .timeout(timeout), .done(done)
  );

  quiz_round_ctrl #(.TICK_DIV(4), .ROUND_SEC(3), .ROUNDS(15)) u_sat (
    .CLK(CLK), .RST(RST), .start(sat_start), .rnd_num(rnd_num), .rnd_run(s_rnd_run),
    .ans_digit(ans_digit), .ans_valid(ans_valid), .product(s_product),
    .time_left(s_time_left), .score(s_score), .round_no(s_round_no), .busy(s_busy),
    .correct(s_correct), .wrong(s_wrong), .timeout(s_timeout), .done(s_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
`ifdef QUIZ_TIME_BONUS_EN
    bonus = 2;
`else
    bonus = 1;
`endif
    RST = 1'b1; start = 1'b0; sat_start = 1'b0;
    rnd_num = 4'd0; ans_digit = 4'd0; ans_valid = 1'b0;
    repeat (2) cyc();
    check("rst_product", 32'(product), 0);
    check("rst_time_left", 32'(time_left), 0);
    check("rst_score", 32'(score), 0);
    check("rst_round_no", 32'(round_no), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rnd_run", 32'(rnd_run), 0);
    RST = 1'b0;
    cyc();

    // Game 1, round 1: redraw on 1, then 6 x 7
    start = 1'b1; cyc(); start = 1'b0;
    check("g1_draw_pulse", 32'(rnd_run), 1);
    check("g1_busy", 32'(busy), 1);
    check("g1_round1", 32'(round_no), 1);
    rnd_num = 4'd1; cyc();
    check("g1_pulse_low", 32'(rnd_run), 0);
    cyc();
    check("g1_redraw_pulse", 32'(rnd_run), 1);
    rnd_num = 4'd6; cyc(); cyc();
    check("g1_drawb_pulse", 32'(rnd_run), 1);
    rnd_num = 4'd7; cyc(); cyc();
    check("g1_show_busy", 32'(busy), 1);
    cyc();
    check("g1_product", 32'(product), 42);
    check("g1_time_load", 32'(time_left), 3);
    ans_valid = 1'b1; ans_digit = 4'd7; cyc();
    ans_digit = 4'd6; cyc();
    ans_valid = 1'b0;
    exp_score = bonus;
    check("r1_correct", 32'(correct), 1);
    check("r1_wrong", 32'(wrong), 0);
    check("r1_timeout", 32'(timeout), 0);
    check("r1_score", 32'(score), 32'(exp_score));
    cyc();
    check("r1_pulse_clear", 32'(correct), 0);
    check("r2_round_no", 32'(round_no), 2);
    check("r2_draw_pulse", 32'(rnd_run), 1);

    // Round 2: 42 again, wrong answer 5 x 8
    rnd_num = 4'd6; cyc(); cyc();
    rnd_num = 4'd7; cyc(); cyc(); cyc();
    check("r2_product", 32'(product), 42);
    ans_valid = 1'b1; ans_digit = 4'd5; cyc();
    ans_digit = 4'd8; cyc();
    ans_valid = 1'b0;
    check("r2_wrong", 32'(wrong), 1);
    check("r2_correct", 32'(correct), 0);
    check("r2_score", 32'(score), 32'(exp_score));
    cyc();
    check("g1_done", 32'(done), 1);
    check("g1_done_busy", 32'(busy), 0);
    check("g1_hold_product", 32'(product), 42);
    check("g1_hold_score", 32'(score), 32'(exp_score));

    // Game 2, round 1: 3 x 9, no answer -> timeout
    start = 1'b1; cyc(); start = 1'b0;
    check("g2_done_clr", 32'(done), 0);
    check("g2_score_clr", 32'(score), 0);
    check("g2_round1", 32'(round_no), 1);
    rnd_num = 4'd3; cyc(); cyc();
    rnd_num = 4'd9; cyc(); cyc(); cyc();
    check("g2_product", 32'(product), 27);
    repeat (4) cyc();
    check("to_tl2", 32'(time_left), 2);
    repeat (4) cyc();
    check("to_tl1", 32'(time_left), 1);
    repeat (3) cyc();
    check("to_early", 32'(timeout), 0);
    cyc();
    check("to_pulse", 32'(timeout), 1);
    check("to_tl0", 32'(time_left), 0);
    check("to_no_correct", 32'(correct), 0);
    check("to_score", 32'(score), 0);
    cyc();
    check("to_pulse_clr", 32'(timeout), 0);
    check("g2_round2", 32'(round_no), 2);

    // Round 2: 4 x 9 = 36, answered 6 x 6 on the final tick
    rnd_num = 4'd4; cyc(); cyc();
    rnd_num = 4'd9; cyc(); cyc(); cyc();
    check("col_product", 32'(product), 36);
    ans_valid = 1'b1; ans_digit = 4'd6; cyc();
    ans_valid = 1'b0;
    repeat (3) cyc();
    check("col_tl2", 32'(time_left), 2);
    repeat (4) cyc();
    check("col_tl1", 32'(time_left), 1);
    repeat (3) cyc();
    ans_valid = 1'b1; ans_digit = 4'd6; cyc();
    ans_valid = 1'b0;
    check("col_correct", 32'(correct), 1);
    check("col_no_timeout", 32'(timeout), 0);
    check("col_tl_kept", 32'(time_left), 1);
    check("col_score", 32'(score), 1);
    cyc();
    check("g2_done", 32'(done), 1);

    // Saturation: 15 rounds of 2 x 2 = 4, answered 1 x 4
    exp_score = 0;
    sat_start = 1'b1; cyc(); sat_start = 1'b0;
    rnd_num = 4'd2;
    for (int r = 1; r <= 15; r++) begin
      repeat (5) cyc();
      ans_valid = 1'b1; ans_digit = 4'd1; cyc();
      ans_digit = 4'd4; cyc();
      ans_valid = 1'b0;
      exp_score = (exp_score + bonus > 15) ? 15 : exp_score + bonus;
      check("sat_correct", 32'(s_correct), 1);
      check("sat_score", 32'(s_score), 32'(exp_score));
      cyc();
    end
    check("sat_done", 32'(s_done), 1);
    check("sat_final", 32'(s_score), 15);
    check("main_ignores", 32'(done), 1);

    // Reset while in ANS2
    start = 1'b1; cyc(); start = 1'b0;
    rnd_num = 4'd9; repeat (5) cyc();
    check("rs_product", 32'(product), 81);
    ans_valid = 1'b1; ans_digit = 4'd9; cyc();
    ans_valid = 1'b0;
    cyc();
    #2 RST = 1'b1;
    #1;
    check("mid_product", 32'(product), 0);
    check("mid_time_left", 32'(time_left), 0);
    check("mid_score", 32'(score), 0);
    check("mid_round_no", 32'(round_no), 0);
    check("mid_busy", 32'(busy), 0);
    check("mid_done", 32'(done), 0);
    check("mid_pulses", 32'({rnd_run, correct, wrong, timeout}), 0);
    #3 RST = 1'b0;
    repeat (3) cyc();
    check("post_idle_busy", 32'(busy), 0);
    check("post_idle_run", 32'(rnd_run), 0);
    start = 1'b1; cyc(); start = 1'b0;
    check("post_start_busy", 32'(busy), 1);
    check("post_start_round", 32'(round_no), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
